// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_scheduler
//  Description : Time-slices a shared seven-segment display between four
//                requesting sources (round-robin, HOLD_CYCLES per slot) and an
//                urgent alert channel that preempts the rotation.
//  Revision    : 1.0  initial release
// ============================================================================
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [3:0]   req,
    input  logic [127:0] src_data,
    input  logic         alert,
    input  logic [31:0]  alert_data,
    output logic [3:0]   grant,
    output logic [31:0]  disp_data,
    output logic [2:0]   disp_src,
    output logic         disp_valid
);

    // Counter reload value: a slot covers counts HOLD_CYCLES-1 down to 0.
    localparam logic [31:0] c_RELOAD    = 32'(HOLD_CYCLES - 1);
    localparam logic [2:0]  c_SRC_ALERT = 3'd4;
    localparam logic [2:0]  c_SRC_NONE  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_ALERT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_last_src;
    logic [31:0] r_disp_data;
    logic [2:0]  r_disp_src;
    logic        r_disp_valid;
    logic [3:0]  r_grant;

    state_t      w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [1:0]  w_last_nxt;
    logic [31:0] w_data_nxt;
    logic [2:0]  w_src_nxt;
    logic        w_valid_nxt;
    logic [3:0]  w_grant_nxt;

    logic        w_found;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic        w_go_alert;
    logic        w_go_arb;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_src + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and next-output decode; alert always beats a new grant.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_src;
        w_data_nxt  = r_disp_data;
        w_src_nxt   = r_disp_src;
        w_valid_nxt = r_disp_valid;
        w_grant_nxt = 4'b0000;
        w_go_alert  = 1'b0;
        w_go_arb    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_go_alert = alert;
                w_go_arb   = !alert;
            end
            S_SHOW: begin
                if (alert) begin
                    w_go_alert = 1'b1;
                end else if (r_cnt == 32'd0) begin
                    w_go_arb = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            S_ALERT: begin
                // Stay for the minimum hold and for as long as alert persists.
                if (r_cnt != 32'd0 || alert) begin
                    w_data_nxt = alert_data;
                    if (r_cnt != 32'd0) begin
                        w_cnt_nxt = r_cnt - 32'd1;
                    end
                end else begin
                    w_go_arb = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_go_alert) begin
            w_state_nxt = S_ALERT;
            w_cnt_nxt   = c_RELOAD;
            w_data_nxt  = alert_data;
            w_src_nxt   = c_SRC_ALERT;
            w_valid_nxt = 1'b1;
        end else if (w_go_arb) begin
            if (w_found) begin
                w_state_nxt = S_SHOW;
                w_cnt_nxt   = c_RELOAD;
                w_data_nxt  = src_data[{w_win, 5'd0} +: 32];
                w_src_nxt   = {1'b0, w_win};
                w_valid_nxt = 1'b1;
                w_grant_nxt = 4'b0001 << w_win;
                w_last_nxt  = w_win;
            end else begin
                // Display keeps its last word so it stays readable while idle.
                w_state_nxt = S_IDLE;
                w_src_nxt   = c_SRC_NONE;
                w_valid_nxt = 1'b0;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= 32'd0;
            r_last_src   <= 2'd3;
            r_disp_data  <= 32'h0;
            r_disp_src   <= c_SRC_NONE;
            r_disp_valid <= 1'b0;
            r_grant      <= 4'b0000;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_src   <= w_last_nxt;
            r_disp_data  <= w_data_nxt;
            r_disp_src   <= w_src_nxt;
            r_disp_valid <= w_valid_nxt;
            r_grant      <= w_grant_nxt;
        end
    end

    assign grant      = r_grant;
    assign disp_data  = r_disp_data;
    assign disp_src   = r_disp_src;
    assign disp_valid = r_disp_valid;

endmodule
`default_nettype wire
